// File: rtl/wdt_cmd_sequencer.sv
// Watchdog command sequencer: round-robin accepts START/KICK/STOP/RELOAD commands
// and expands each one into ordered single-register pushes to the WDEN/WDLIVE/WTOCNT FIFOs.
module wdt_cmd_sequencer #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [2*NREQ-1:0]          req_cmd,
  input  logic [CNT_W*NREQ-1:0]      req_data,
  input  logic                       wdt_timeout,
  input  logic                       wden_full,
  input  logic                       wdlive_full,
  input  logic                       wtocnt_full,
  output logic                       wden_push,
  output logic                       wdlive_push,
  output logic                       wtocnt_push,
  output logic [CNT_W-1:0]           push_data,
  output logic                       busy,
  output logic                       wdt_active,
  output logic                       timeout_flag,
  output logic                       cmd_err,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] CMD_START  = 2'b00;
  localparam logic [1:0] CMD_KICK   = 2'b01;
  localparam logic [1:0] CMD_STOP   = 2'b10;
  localparam logic [1:0] CMD_RELOAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_TOCNT, S_EN1, S_EN0, S_LIVE1, S_LIVE0
  } state_t;

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant_q;
  logic [CNT_W-1:0] data_q;
  logic             en_after_q;   // TOCNT push is followed by EN(1)
  logic             reload_q;     // EN(0) push is followed by TOCNT
  logic             active_q;
  logic             tflag_q;
  logic             to_q;
  logic             cmd_err_q;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   scan_idx;
  logic [1:0]       cmd_sel;
  logic [CNT_W-1:0] data_sel;
  logic             accept;
  logic             cmd_ok;
  logic             to_rise;

  // Round-robin scan starting at rr_ptr, first valid requester wins
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = IDW'((32'(rr_ptr) + 32'(i)) % NREQ);
      if (!found && req_valid[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  always_comb begin
    cmd_sel  = '0;
    data_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == win) begin
        cmd_sel  = req_cmd[2*i +: 2];
        data_sel = req_data[CNT_W*i +: CNT_W];
      end
    end
  end

  always_comb begin
    accept    = rst && (state == S_IDLE) && found;
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    cmd_ok = 1'b0;
    case (cmd_sel)
      CMD_START:  cmd_ok = !active_q && (data_sel != '0);
      CMD_KICK:   cmd_ok = active_q && !tflag_q;
      CMD_STOP:   cmd_ok = active_q;
      CMD_RELOAD: cmd_ok = (data_sel != '0);
      default:    cmd_ok = 1'b0;
    endcase
  end

  // Push strobes react to the full flags in the same cycle
  always_comb begin
    wtocnt_push = (state == S_TOCNT) && !wtocnt_full;
    wden_push   = ((state == S_EN1) || (state == S_EN0)) && !wden_full;
    wdlive_push = ((state == S_LIVE1) || (state == S_LIVE0)) && !wdlive_full;
    push_data   = '0;
    case (state)
      S_TOCNT:      push_data = data_q;
      S_EN1, S_LIVE1: push_data = CNT_W'(1);
      default:      push_data = '0;
    endcase
  end

  assign to_rise      = wdt_timeout && !to_q;
  assign busy         = (state != S_IDLE);
  assign wdt_active   = active_q;
  assign timeout_flag = tflag_q;
  assign cmd_err      = cmd_err_q;
  assign grant_id     = grant_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_q    <= '0;
      data_q     <= '0;
      en_after_q <= 1'b0;
      reload_q   <= 1'b0;
      active_q   <= 1'b0;
      tflag_q    <= 1'b0;
      to_q       <= 1'b0;
      cmd_err_q  <= 1'b0;
    end else begin
      to_q      <= wdt_timeout;
      cmd_err_q <= 1'b0;

      // A new timeout edge beats a same-cycle START clear
      if (to_rise)
        tflag_q <= 1'b1;
      else if (accept && cmd_ok && (cmd_sel == CMD_START))
        tflag_q <= 1'b0;

      if (to_rise)
        active_q <= 1'b0;
      else if (wden_push)
        active_q <= (state == S_EN1);

      case (state)
        S_IDLE: begin
          if (accept) begin
            rr_ptr  <= IDW'((32'(win) + 32'd1) % NREQ);
            grant_q <= win;
            if (!cmd_ok) begin
              cmd_err_q <= 1'b1;
            end else begin
              data_q <= data_sel;
              case (cmd_sel)
                CMD_START: begin
                  state      <= S_TOCNT;
                  en_after_q <= 1'b1;
                end
                CMD_KICK: state <= S_LIVE1;
                CMD_STOP: begin
                  state    <= S_EN0;
                  reload_q <= 1'b0;
                end
                default: begin
                  if (active_q) begin
                    state      <= S_EN0;
                    reload_q   <= 1'b1;
                    en_after_q <= 1'b1;
                  end else begin
                    state      <= S_TOCNT;
                    en_after_q <= 1'b0;
                  end
                end
              endcase
            end
          end
        end
        S_TOCNT: if (wtocnt_push) state <= en_after_q ? S_EN1 : S_IDLE;
        S_EN1:   if (wden_push)   state <= S_IDLE;
        S_EN0:   if (wden_push)   state <= reload_q ? S_TOCNT : S_IDLE;
        S_LIVE1: if (wdlive_push) state <= S_LIVE0;
        S_LIVE0: if (wdlive_push) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wdt_cmd_sequencer.sv
// Self-checking bench for wdt_cmd_sequencer: expected FIFO pushes are queued when
// commands are driven and compared in order as the DUT issues them.
module tb_wdt_cmd_sequencer;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned CNT_W = 32;

  localparam logic [1:0] C_START  = 2'b00;
  localparam logic [1:0] C_KICK   = 2'b01;
  localparam logic [1:0] C_STOP   = 2'b10;
  localparam logic [1:0] C_RELOAD = 2'b11;

  localparam logic [1:0] K_TOCNT = 2'd1;
  localparam logic [1:0] K_EN    = 2'd2;
  localparam logic [1:0] K_LIVE  = 2'd3;

  typedef struct {
    logic [1:0]       kind;
    logic [CNT_W-1:0] data;
  } push_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [2*NREQ-1:0]     req_cmd;
  logic [CNT_W*NREQ-1:0] req_data;
  logic                  wdt_timeout;
  logic                  wden_full, wdlive_full, wtocnt_full;
  logic                  wden_push, wdlive_push, wtocnt_push;
  logic [CNT_W-1:0]      push_data;
  logic                  busy, wdt_active, timeout_flag, cmd_err;
  logic [0:0]            grant_id;

  int    total = 0;
  int    bad   = 0;
  push_t exp_q[$];

  wdt_cmd_sequencer #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_data(req_data),
    .wdt_timeout(wdt_timeout),
    .wden_full(wden_full), .wdlive_full(wdlive_full), .wtocnt_full(wtocnt_full),
    .wden_push(wden_push), .wdlive_push(wdlive_push), .wtocnt_push(wtocnt_push),
    .push_data(push_data), .busy(busy), .wdt_active(wdt_active),
    .timeout_flag(timeout_flag), .cmd_err(cmd_err), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] c, input logic [CNT_W-1:0] d);
    req_cmd[2*r +: 2]         = c;
    req_data[CNT_W*r +: CNT_W] = d;
    req_valid[r]              = 1'b1;
  endtask

  task automatic clear_req();
    req_valid = '0;
  endtask

  task automatic expect_push(input logic [1:0] k, input logic [CNT_W-1:0] d);
    push_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One-cycle command from a single requester, then wait (bounded) for idle
  task automatic run_cmd(input string tag, input int r, input logic [1:0] c,
                         input logic [CNT_W-1:0] d);
    int n;
    tick();
    set_req(r, c, d);
    tick();
    clear_req();
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  // Scoreboard: every observed push must match the head of the expected queue
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      int          n;
      logic [1:0]  k;
      push_t       e;
      n = int'(wden_push) + int'(wdlive_push) + int'(wtocnt_push);
      k = wtocnt_push ? K_TOCNT : (wden_push ? K_EN : (wdlive_push ? K_LIVE : 2'd0));
      if (n > 1) begin
        check("one_push_per_cycle", 64'(n), 64'd1);
      end else if (n == 1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_push", 64'(k), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("push_kind", 64'(k), 64'(e.kind));
          check("push_data", 64'(push_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    req_valid = '1;
    req_cmd = '0;
    req_data = '0;
    wdt_timeout = 1'b0;
    wden_full = 1'b0;
    wdlive_full = 1'b0;
    wtocnt_full = 1'b0;

    // Reset values, with requests pending that must not be accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_active", 64'(wdt_active), 64'd0);
    check("rst_tflag", 64'(timeout_flag), 64'd0);
    check("rst_cmd_err", 64'(cmd_err), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_pushes", 64'({wden_push, wdlive_push, wtocnt_push}), 64'd0);
    check("rst_push_data", 64'(push_data), 64'd0);
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;

    // START req0 0x100: TOCNT at T+1, EN(1) at T+2, idle and active at T+3
    tick();
    set_req(0, C_START, 32'h100);
    expect_push(K_TOCNT, 32'h100);
    expect_push(K_EN, 32'd1);
    @(negedge clk);
    check("start_ready", 64'(req_ready), 64'b01);
    tick();
    clear_req();
    @(negedge clk);
    check("start_tocnt_t1", 64'(wtocnt_push), 64'd1);
    check("start_busy_t1", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    check("start_en_t2", 64'(wden_push), 64'd1);
    tick();
    @(negedge clk);
    check("start_active_t3", 64'(wdt_active), 64'd1);
    check("start_busy_t3", 64'(busy), 64'd0);
    check("start_grant", 64'(grant_id), 64'd0);

    // RELOAD with data 0 from req1 is rejected; also moves rr back to 0
    tick();
    set_req(1, C_RELOAD, 32'd0);
    @(negedge clk);
    check("rl0_ready", 64'(req_ready), 64'b10);
    tick();
    clear_req();
    @(negedge clk);
    check("rl0_cmd_err", 64'(cmd_err), 64'd1);
    check("rl0_busy", 64'(busy), 64'd0);
    tick();
    @(negedge clk);
    check("rl0_err_pulse", 64'(cmd_err), 64'd0);

    // Two simultaneous KICKs: req0 then req1
    tick();
    set_req(0, C_KICK, 32'd0);
    set_req(1, C_KICK, 32'd0);
    repeat (2) begin
      expect_push(K_LIVE, 32'd1);
      expect_push(K_LIVE, 32'd0);
    end
    @(negedge clk);
    check("kick_ready_t0", 64'(req_ready), 64'b01);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("kick_live_t1", 64'(wdlive_push), 64'd1);
    check("kick_no_ready_busy", 64'(req_ready), 64'd0);
    check("kick_grant0", 64'(grant_id), 64'd0);
    tick();
    @(negedge clk);
    check("kick_live_t2", 64'(wdlive_push), 64'd1);
    tick();
    @(negedge clk);
    check("kick_ready_t3", 64'(req_ready), 64'b10);
    tick();
    clear_req();
    @(negedge clk);
    check("kick_live_t4", 64'(wdlive_push), 64'd1);
    check("kick_grant1", 64'(grant_id), 64'd1);
    tick();
    @(negedge clk);
    check("kick_live_t5", 64'(wdlive_push), 64'd1);

    // STOP, then KICK while inactive is rejected
    expect_push(K_EN, 32'd0);
    run_cmd("stop_idle", 0, C_STOP, 32'd0);
    @(negedge clk);
    check("stop_inactive", 64'(wdt_active), 64'd0);
    tick();
    set_req(0, C_KICK, 32'd0);
    tick();
    clear_req();
    @(negedge clk);
    check("kick_inact_err", 64'(cmd_err), 64'd1);
    check("kick_inact_busy", 64'(busy), 64'd0);

    // RELOAD 0x40 while active, WTOCNT full stalls the middle push
    expect_push(K_TOCNT, 32'h200);
    expect_push(K_EN, 32'd1);
    run_cmd("start200_idle", 1, C_START, 32'h200);
    tick();
    set_req(0, C_RELOAD, 32'h40);
    wtocnt_full = 1'b1;
    expect_push(K_EN, 32'd0);
    expect_push(K_TOCNT, 32'h40);
    expect_push(K_EN, 32'd1);
    tick();
    clear_req();
    @(negedge clk);
    check("rl_en0_t1", 64'(wden_push), 64'd1);
    tick();
    @(negedge clk);
    check("rl_stall_t2", 64'(wtocnt_push), 64'd0);
    tick();
    @(negedge clk);
    check("rl_stall_t3", 64'(wtocnt_push), 64'd0);
    check("rl_stall_busy", 64'(busy), 64'd1);
    tick();
    wtocnt_full = 1'b0;
    @(negedge clk);
    check("rl_tocnt_t4", 64'(wtocnt_push), 64'd1);
    tick();
    @(negedge clk);
    check("rl_en1_t5", 64'(wden_push), 64'd1);
    tick();
    @(negedge clk);
    check("rl_active", 64'(wdt_active), 64'd1);
    check("rl_idle", 64'(busy), 64'd0);

    // Timeout edge while idle
    tick();
    wdt_timeout = 1'b1;
    tick();
    @(negedge clk);
    check("to_flag", 64'(timeout_flag), 64'd1);
    check("to_inactive", 64'(wdt_active), 64'd0);
    tick();
    set_req(0, C_KICK, 32'd0);
    tick();
    clear_req();
    @(negedge clk);
    check("to_kick_err", 64'(cmd_err), 64'd1);
    tick();
    set_req(0, C_START, 32'd5);
    expect_push(K_TOCNT, 32'd5);
    expect_push(K_EN, 32'd1);
    tick();
    clear_req();
    @(negedge clk);
    check("to_start_clear", 64'(timeout_flag), 64'd0);
    check("to_start_tocnt", 64'(wtocnt_push), 64'd1);
    tick();
    tick();
    @(negedge clk);
    check("to_start_active", 64'(wdt_active), 64'd1);
    wdt_timeout = 1'b0;

    // RELOAD while inactive pushes TOCNT only
    expect_push(K_EN, 32'd0);
    run_cmd("stop2_idle", 0, C_STOP, 32'd0);
    expect_push(K_TOCNT, 32'd7);
    run_cmd("rl_inact_idle", 1, C_RELOAD, 32'd7);
    @(negedge clk);
    check("rl_inact_active", 64'(wdt_active), 64'd0);
    expect_push(K_TOCNT, 32'd9);
    expect_push(K_EN, 32'd1);
    run_cmd("start9_idle", 0, C_START, 32'd9);

    // Reset after the first push of a RELOAD aborts the rest
    tick();
    set_req(1, C_RELOAD, 32'h33);
    expect_push(K_EN, 32'd0);
    tick();
    clear_req();
    @(negedge clk);
    check("abort_en0", 64'(wden_push), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_pushes", 64'({wden_push, wdlive_push, wtocnt_push}), 64'd0);
    check("abort_active", 64'(wdt_active), 64'd0);
    check("abort_grant", 64'(grant_id), 64'd0);
    check("abort_push_data", 64'(push_data), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    set_req(0, C_KICK, 32'd0);
    set_req(1, C_KICK, 32'd0);
    @(negedge clk);
    check("abort_rr0", 64'(req_ready), 64'b01);
    tick();
    clear_req();
    @(negedge clk);
    check("abort_kick_err", 64'(cmd_err), 64'd1);

    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
